mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
Shares the single external program/data memory bus between three requesters: instruction fetch (IF), control-unit load/store (LS) and a debug/loader port (DBG).
- Runs each access as a multi-cycle transaction with a parameterised wait-state count.
- Drives the memory address, write enable and write data, and returns read data with a per-requester done pulse.
- Sits between program_counter/control_unit and the top-level tristate bus driver, replacing the combinational address mux.

Parameters:
ADDR_WIDTH, 8, address width of all ports
DATA_WIDTH, 8, data width of all ports
WAIT_STATES, 1, extra bus cycles per access; legal range 0..15

Ports:
clk  in  1  system clock
rst  in  1  reset
if_req  in  1  fetch request, read only
if_addr  in  ADDR_WIDTH  fetch address
if_done  out  1  one-cycle completion pulse for IF
ls_req  in  1  load/store request
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_WIDTH  load/store address
ls_wdata  in  DATA_WIDTH  store data
ls_done  out  1  completion pulse for LS
dbg_req  in  1  debug request
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  ADDR_WIDTH  debug address
dbg_wdata  in  DATA_WIDTH  debug write data
dbg_done  out  1  completion pulse for DBG
rd_data  out  DATA_WIDTH  read data of the last completed access
mem_addr  out  ADDR_WIDTH  memory address
mem_write_en  out  1  memory write strobe
mem_wdata  out  DATA_WIDTH  data toward the tristate driver
mem_rdata  in  DATA_WIDTH  data from memory
busy  out  1  transaction in progress
owner  out  2  0 = none, 1 = IF, 2 = LS, 3 = DBG

Interface decision: one clock; reset is synchronous and active-high. All outputs are registered.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; wait counter 0; round-robin pointer favours LS.
- Reset takes priority over every other event in the same cycle.
- FSM states: IDLE, ACCESS.
- IDLE, no eligible request: hold mem_addr and mem_wdata; mem_write_en=0; busy=0; owner=0.
- IDLE, eligible request in cycle N:
  - Select a winner and latch its addr, we and wdata into mem_addr, mem_write_en and mem_wdata.
  - Set owner and busy=1; load counter with WAIT_STATES; go to ACCESS.
  - Outputs are valid from cycle N+1.
- ACCESS, counter>0: decrement; all bus outputs hold.
- ACCESS, counter==0:
  - rd_data <= mem_rdata, for writes as well; owner's done <= 1.
  - mem_write_en <= 0; busy <= 0; owner <= 0; go to IDLE.
- Timing: bus is driven for WAIT_STATES+1 cycles (N+1 .. N+1+WAIT_STATES); done is high in cycle N+2+WAIT_STATES for exactly one cycle.
- The done cycle is itself an IDLE cycle. In it, the completing requester's req is masked; other requesters may win.
  - Minimum same-requester period: WAIT_STATES+3 cycles.
- rd_data holds until the next completion.
- Default priority: DBG > LS > IF.
- Requesters must hold req/addr/we/wdata stable until their done. Inputs are latched at grant, so later changes are ignored and the access completes regardless.
- Dropping req mid-access does not abort: done still pulses.
- Only one done is high per cycle; done never pulses without a prior grant.
- Reset in ACCESS aborts the access: mem_write_en=0 after the edge, no done pulse, rd_data=0.

Optional Feature:
ARB_RR_EN
- Defined: DBG keeps absolute priority. A 1-bit pointer arbitrates between LS and IF:
  - on an LS/IF tie, the requester not served last wins;
  - the pointer updates on each LS or IF grant.
- Undefined: fixed priority DBG > LS > IF, and no pointer register exists.

Test Plan:
- WAIT_STATES=1, if_req with if_addr=0x10, mem_rdata=0xA5 -> mem_addr=0x10 in cycles 1–2, if_done high in cycle 3 only, rd_data=0xA5, owner=1 during the access.
- ls store to 0x80 with ls_wdata=0x3C -> mem_write_en high exactly WAIT_STATES+1 cycles, mem_wdata=0x3C, single ls_done, if_done/dbg_done stay 0.
- if_req, ls_req and dbg_req asserted together and held until done then dropped -> grant order DBG, LS, IF (macro off).
  - With ARB_RR_EN and IF+LS held continuously -> grants alternate LS, IF, LS, IF.
- WAIT_STATES=0, if_req held high with incrementing address -> if_done every 3 cycles.
  - req still high in the done cycle is not regranted that cycle.
  - rd_data is stable between pulses.
- rst asserted in the second cycle of an LS store -> next edge: mem_write_en=0, busy=0, owner=0, no ls_done. A fresh request after reset completes normally.
- dbg_req dropped after grant -> access completes, dbg_done pulses once; a subsequent if_req is granted in the done cycle.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Multi-cycle arbiter for the shared program/data memory bus (IF, LS, DBG requesters).
// Define ARB_RR_EN to round-robin LS/IF ties; DBG always keeps absolute priority.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_done,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [1:0]            owner
);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS, OWN_DBG} owner_t;

  state_t state;
  logic [3:0] cnt;
  logic if_elig, ls_elig, dbg_elig;
  owner_t win;

  // A requester whose done is high this cycle is still holding req; it must not be regranted yet.
  always_comb begin
    if_elig  = if_req  & ~if_done;
    ls_elig  = ls_req  & ~ls_done;
    dbg_elig = dbg_req & ~dbg_done;
  end

`ifdef ARB_RR_EN
  logic if_turn;  // 1: IF wins the next LS/IF tie

  always_comb begin
    win = OWN_NONE;
    if (dbg_elig)               win = OWN_DBG;
    else if (ls_elig && if_elig) win = if_turn ? OWN_IF : OWN_LS;
    else if (ls_elig)           win = OWN_LS;
    else if (if_elig)           win = OWN_IF;
  end

  always_ff @(posedge clk) begin
    if (rst)
      if_turn <= 1'b0;
    else if (state == IDLE && win == OWN_LS)
      if_turn <= 1'b1;
    else if (state == IDLE && win == OWN_IF)
      if_turn <= 1'b0;
  end
`else
  always_comb begin
    win = OWN_NONE;
    if (dbg_elig)     win = OWN_DBG;
    else if (ls_elig) win = OWN_LS;
    else if (if_elig) win = OWN_IF;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      if_done      <= 1'b0;
      ls_done      <= 1'b0;
      dbg_done     <= 1'b0;
      rd_data      <= '0;
      mem_addr     <= '0;
      mem_write_en <= 1'b0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      owner        <= '0;
    end else begin
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      dbg_done <= 1'b0;
      case (state)
        IDLE: begin
          mem_write_en <= 1'b0;
          busy         <= 1'b0;
          owner        <= '0;
          if (win != OWN_NONE) begin
            owner <= win;
            busy  <= 1'b1;
            cnt   <= 4'(WAIT_STATES);
            state <= ACCESS;
            case (win)
              OWN_DBG: begin
                mem_addr     <= dbg_addr;
                mem_write_en <= dbg_we;
                mem_wdata    <= dbg_wdata;
              end
              OWN_LS: begin
                mem_addr     <= ls_addr;
                mem_write_en <= ls_we;
                mem_wdata    <= ls_wdata;
              end
              default: begin
                mem_addr     <= if_addr;
                mem_write_en <= 1'b0;
              end
            endcase
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rd_data      <= mem_rdata;
            if_done      <= (owner == OWN_IF);
            ls_done      <= (owner == OWN_LS);
            dbg_done     <= (owner == OWN_DBG);
            mem_write_en <= 1'b0;
            busy         <= 1'b0;
            owner        <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
